// File: rtl/laser_sdram_arbiter.sv
// Shares one 8-bit SDRAM port between video fetch, the Z80 CPU and a one-entry ioctl download buffer.
// Each grant opens a fixed SLOT_CYC-cycle window. The window is followed by a DONE cycle that acks the requester and may grant again.
module laser_sdram_arbiter #(
   parameter int                ADDR_W   = 25,
   parameter int                SLOT_CYC = 4,
   parameter logic [ADDR_W-1:0] PRG_BASE = 25'h08995,
   parameter int                CPU_AGE  = 2
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              vid_req,
   input  logic [ADDR_W-1:0] vid_addr,
   output logic              vid_ack,
   output logic [7:0]        vid_data,
   input  logic              cpu_req,
   input  logic              cpu_we,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [7:0]        cpu_wdata,
   output logic              cpu_ack,
   output logic [7:0]        cpu_rdata,
   input  logic              ioctl_download,
   input  logic              ioctl_wr,
   input  logic [ADDR_W-1:0] ioctl_addr,
   input  logic [7:0]        ioctl_data,
   output logic              dl_busy,
   output logic              dl_overrun,
   output logic [ADDR_W-1:0] sdram_addr,
   output logic              sdram_rd,
   output logic              sdram_wr,
   output logic [7:0]        sdram_din,
   input  logic [7:0]        sdram_dout
);

   localparam int CNT_W = $clog2(SLOT_CYC + 1);
   localparam int AGE_W = (CPU_AGE < 1) ? 1 : $clog2(CPU_AGE + 1);

   typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_DONE} state_t;
   typedef enum logic [2:0] {G_NONE, G_VID, G_CPU_RD, G_CPU_WR, G_DL} gnt_t;

   state_t            state_q, state_d;
   gnt_t              gnt_q, gnt_d, sel;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [AGE_W-1:0]  age_q, age_d;
   logic              vid_ack_q, vid_ack_d, cpu_ack_q, cpu_ack_d;
   logic [7:0]        vid_data_q, vid_data_d, cpu_rdata_q, cpu_rdata_d;
   logic [ADDR_W-1:0] sdram_addr_q, sdram_addr_d;
   logic              sdram_rd_q, sdram_rd_d, sdram_wr_q, sdram_wr_d;
   logic [7:0]        sdram_din_q, sdram_din_d;
   logic              buf_full_q, buf_full_d;
   logic [ADDR_W-1:0] buf_addr_q, buf_addr_d;
   logic [7:0]        buf_data_q, buf_data_d;
   logic              dl_overrun_q, dl_overrun_d, dl_prev_q, dl_prev_d;
   logic              vid_pend, cpu_pend, cpu_old, dl_strobe, dl_rise, dl_grant;

   // A requester being acked this cycle is not pending, so a req that drops on ack is never served twice.
   always_comb begin
      vid_pend = vid_req & ~vid_ack_q;
      cpu_pend = cpu_req & ~cpu_ack_q;
      cpu_old  = (age_q >= AGE_W'(CPU_AGE));
      sel      = G_NONE;
      if (state_q != S_ACCESS) begin
         if (vid_pend)
            sel = G_VID;
         else if (cpu_pend && (cpu_old || !buf_full_q))
            sel = cpu_we ? G_CPU_WR : G_CPU_RD;
         else if (buf_full_q)
            sel = G_DL;
      end
   end

   assign dl_grant  = (sel == G_DL);
   assign dl_strobe = ioctl_wr & ioctl_download;
   assign dl_rise   = ioctl_download & ~dl_prev_q;

   always_comb begin
      state_d      = state_q;
      gnt_d        = gnt_q;
      cnt_d        = cnt_q;
      age_d        = age_q;
      vid_ack_d    = 1'b0;
      cpu_ack_d    = 1'b0;
      vid_data_d   = vid_data_q;
      cpu_rdata_d  = cpu_rdata_q;
      sdram_addr_d = sdram_addr_q;
      sdram_rd_d   = 1'b0;
      sdram_wr_d   = 1'b0;
      sdram_din_d  = sdram_din_q;
      buf_full_d   = buf_full_q;
      buf_addr_d   = buf_addr_q;
      buf_data_d   = buf_data_q;
      dl_overrun_d = dl_overrun_q;
      dl_prev_d    = ioctl_download;

      case (state_q)
         S_ACCESS: begin
            if (cnt_q == CNT_W'(SLOT_CYC)) begin
               state_d = S_DONE;
               case (gnt_q)
                  G_VID:    begin vid_data_d  = sdram_dout; vid_ack_d = 1'b1; end
                  G_CPU_RD: begin cpu_rdata_d = sdram_dout; cpu_ack_d = 1'b1; end
                  G_CPU_WR: cpu_ack_d = 1'b1;
                  default:  ;
               endcase
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: ;
      endcase

      if (sel != G_NONE) begin
         state_d = S_ACCESS;
         gnt_d   = sel;
         cnt_d   = CNT_W'(1);
         case (sel)
            G_VID: begin
               sdram_addr_d = vid_addr;
               sdram_rd_d   = 1'b1;
            end
            G_CPU_RD: begin
               sdram_addr_d = cpu_addr;
               sdram_rd_d   = 1'b1;
            end
            G_CPU_WR: begin
               sdram_addr_d = cpu_addr;
               sdram_din_d  = cpu_wdata;
               sdram_wr_d   = 1'b1;
            end
            default: begin
               sdram_addr_d = buf_addr_q;
               sdram_din_d  = buf_data_q;
               sdram_wr_d   = 1'b1;
            end
         endcase
      end

      // Age saturates at CPU_AGE; only losses while the CPU was actually waiting count.
      if (sel == G_CPU_RD || sel == G_CPU_WR)
         age_d = '0;
      else if (sel != G_NONE && cpu_pend && !cpu_old)
         age_d = age_q + AGE_W'(1);

      if (dl_grant)
         buf_full_d = 1'b0;
      if (dl_rise)
         dl_overrun_d = 1'b0;
      if (dl_strobe) begin
         if (!buf_full_q || dl_grant) begin
            buf_full_d = 1'b1;
            buf_addr_d = PRG_BASE + ioctl_addr;
            buf_data_d = ioctl_data;
         end else begin
            dl_overrun_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q      <= S_IDLE;
         gnt_q        <= G_NONE;
         cnt_q        <= '0;
         age_q        <= '0;
         vid_ack_q    <= 1'b0;
         cpu_ack_q    <= 1'b0;
         vid_data_q   <= '0;
         cpu_rdata_q  <= '0;
         sdram_addr_q <= '0;
         sdram_rd_q   <= 1'b0;
         sdram_wr_q   <= 1'b0;
         sdram_din_q  <= '0;
         buf_full_q   <= 1'b0;
         buf_addr_q   <= '0;
         buf_data_q   <= '0;
         dl_overrun_q <= 1'b0;
         dl_prev_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         gnt_q        <= gnt_d;
         cnt_q        <= cnt_d;
         age_q        <= age_d;
         vid_ack_q    <= vid_ack_d;
         cpu_ack_q    <= cpu_ack_d;
         vid_data_q   <= vid_data_d;
         cpu_rdata_q  <= cpu_rdata_d;
         sdram_addr_q <= sdram_addr_d;
         sdram_rd_q   <= sdram_rd_d;
         sdram_wr_q   <= sdram_wr_d;
         sdram_din_q  <= sdram_din_d;
         buf_full_q   <= buf_full_d;
         buf_addr_q   <= buf_addr_d;
         buf_data_q   <= buf_data_d;
         dl_overrun_q <= dl_overrun_d;
         dl_prev_q    <= dl_prev_d;
      end
   end

   assign vid_ack    = vid_ack_q;
   assign vid_data   = vid_data_q;
   assign cpu_ack    = cpu_ack_q;
   assign cpu_rdata  = cpu_rdata_q;
   assign sdram_addr = sdram_addr_q;
   assign sdram_rd   = sdram_rd_q;
   assign sdram_wr   = sdram_wr_q;
   assign sdram_din  = sdram_din_q;
   assign dl_busy    = ioctl_download | buf_full_q;
   assign dl_overrun = dl_overrun_q;

endmodule

// File: tb/tb_laser_sdram_arbiter.sv
// Scoreboard bench for laser_sdram_arbiter. Expected SDRAM accesses and acks, with their cycle numbers, are queued when stimulus is driven.
// The SDRAM model returns a hash of the address as read data.
module tb_laser_sdram_arbiter;

   logic        clk, reset_n;
   logic        vid_req, vid_ack, cpu_req, cpu_we, cpu_ack;
   logic [24:0] vid_addr, cpu_addr, ioctl_addr, sdram_addr;
   logic [7:0]  vid_data, cpu_wdata, cpu_rdata, ioctl_data, sdram_din, sdram_dout;
   logic        ioctl_download, ioctl_wr, dl_busy, dl_overrun, sdram_rd, sdram_wr;

   laser_sdram_arbiter dut (
      .clk(clk), .reset_n(reset_n),
      .vid_req(vid_req), .vid_addr(vid_addr), .vid_ack(vid_ack), .vid_data(vid_data),
      .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
      .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
      .ioctl_download(ioctl_download), .ioctl_wr(ioctl_wr), .ioctl_addr(ioctl_addr),
      .ioctl_data(ioctl_data), .dl_busy(dl_busy), .dl_overrun(dl_overrun),
      .sdram_addr(sdram_addr), .sdram_rd(sdram_rd), .sdram_wr(sdram_wr),
      .sdram_din(sdram_din), .sdram_dout(sdram_dout)
   );

   assign sdram_dout = sdram_addr[7:0] ^ sdram_addr[15:8] ^ 8'hA4;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct { logic wr; logic [24:0] addr; logic [7:0] data; int cyc; } sd_t;
   typedef struct { logic [7:0] data; int cyc; } ack_t;

   sd_t  sq[$];
   ack_t vq[$], cq[$];
   int   cyc = 0, nchk = 0, npass = 0;

   function automatic logic [7:0] rdval(input logic [24:0] a);
      return a[7:0] ^ a[15:8] ^ 8'hA4;
   endfunction

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      nchk++;
      if (got === exp) npass++;
      else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
   endtask

   task automatic mon();
      sd_t  s;
      ack_t a;
      if (sdram_rd || sdram_wr) begin
         if (sq.size() == 0) chk("sdram_unexpected_access", 1, 0);
         else begin
            s = sq.pop_front();
            chk("sdram_wr", 32'(sdram_wr), 32'(s.wr));
            chk("sdram_rd", 32'(sdram_rd), 32'(!s.wr));
            chk("sdram_addr", 32'(sdram_addr), 32'(s.addr));
            if (s.wr) chk("sdram_din", 32'(sdram_din), 32'(s.data));
            chk("sdram_cycle", cyc, s.cyc);
         end
      end
      if (vid_ack) begin
         if (vq.size() == 0) chk("vid_ack_unexpected", 1, 0);
         else begin
            a = vq.pop_front();
            chk("vid_data", 32'(vid_data), 32'(a.data));
            chk("vid_ack_cycle", cyc, a.cyc);
         end
      end
      if (cpu_ack) begin
         if (cq.size() == 0) chk("cpu_ack_unexpected", 1, 0);
         else begin
            a = cq.pop_front();
            chk("cpu_rdata", 32'(cpu_rdata), 32'(a.data));
            chk("cpu_ack_cycle", cyc, a.cyc);
         end
      end
   endtask

   // Requesters hold req through the ack cycle and drop it after the following edge.
   task automatic tick();
      logic va, ca;
      @(negedge clk);
      mon();
      va = vid_ack;
      ca = cpu_ack;
      @(posedge clk);
      cyc++;
      #1;
      if (va) vid_req = 1'b0;
      if (ca) cpu_req = 1'b0;
   endtask

   task automatic drain();
      int n = 0;
      while ((sq.size() + vq.size() + cq.size()) != 0 && n < 200) begin
         tick();
         n++;
      end
      chk("drain_timeout", sq.size() + vq.size() + cq.size(), 0);
      repeat (4) tick();
   endtask

   initial begin
      int k, idx;
      logic [7:0] d3 [3];
      reset_n = 1'b0; vid_req = 1'b0; vid_addr = '0; cpu_req = 1'b0; cpu_we = 1'b0;
      cpu_addr = '0; cpu_wdata = '0; ioctl_download = 1'b0; ioctl_wr = 1'b0;
      ioctl_addr = '0; ioctl_data = '0;
      repeat (3) tick();

      chk("rst_sdram_rd", 32'(sdram_rd), 0);
      chk("rst_sdram_wr", 32'(sdram_wr), 0);
      chk("rst_vid_ack", 32'(vid_ack), 0);
      chk("rst_cpu_ack", 32'(cpu_ack), 0);
      chk("rst_sdram_addr", 32'(sdram_addr), 0);
      chk("rst_vid_data", 32'(vid_data), 0);
      chk("rst_cpu_rdata", 32'(cpu_rdata), 0);
      chk("rst_dl_busy", 32'(dl_busy), 0);
      chk("rst_dl_overrun", 32'(dl_overrun), 0);

      // 1: single video read straight out of reset
      k = cyc;
      reset_n = 1'b1; vid_req = 1'b1; vid_addr = 25'h100;
      sq.push_back('{1'b0, 25'h100, 8'h00, k + 1});
      vq.push_back('{8'hA5, k + 5});
      drain();

      // 2: video and CPU together, video first, back-to-back windows
      k = cyc;
      vid_req = 1'b1; vid_addr = 25'h200;
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 25'h300;
      sq.push_back('{1'b0, 25'h200, 8'h00, k + 1});
      vq.push_back('{rdval(25'h200), k + 5});
      sq.push_back('{1'b0, 25'h300, 8'h00, k + 6});
      cq.push_back('{rdval(25'h300), k + 10});
      drain();

      // 3: three download bytes 8 cycles apart; download drops right after the last one
      d3[0] = 8'h11; d3[1] = 8'h22; d3[2] = 8'h33;
      ioctl_download = 1'b1;
      tick();
      chk("t3_dl_busy", 32'(dl_busy), 1);
      for (int i = 0; i < 3; i++) begin
         k = cyc;
         ioctl_wr = 1'b1; ioctl_addr = 25'(i); ioctl_data = d3[i];
         sq.push_back('{1'b1, 25'h08995 + 25'(i), d3[i], k + 2});
         tick();
         ioctl_wr = 1'b0;
         if (i == 2) ioctl_download = 1'b0;
         repeat (7) tick();
      end
      drain();
      chk("t3_dl_overrun", 32'(dl_overrun), 0);
      chk("t3_dl_busy_idle", 32'(dl_busy), 0);

      // 4: second strobe while the buffer waits behind video is dropped
      ioctl_download = 1'b1;
      tick();
      k = cyc;
      vid_req = 1'b1; vid_addr = 25'h400;
      sq.push_back('{1'b0, 25'h400, 8'h00, k + 1});
      vq.push_back('{rdval(25'h400), k + 5});
      sq.push_back('{1'b1, 25'h0899A, 8'h44, k + 6});
      tick();
      ioctl_wr = 1'b1; ioctl_addr = 25'd5; ioctl_data = 8'h44;
      tick();
      ioctl_wr = 1'b0;
      tick();
      ioctl_wr = 1'b1; ioctl_addr = 25'd6; ioctl_data = 8'h55;
      tick();
      ioctl_wr = 1'b0;
      chk("t4_overrun_set", 32'(dl_overrun), 1);
      drain();
      ioctl_download = 1'b0;
      repeat (2) tick();
      chk("t4_overrun_sticky", 32'(dl_overrun), 1);
      ioctl_download = 1'b1;
      tick();
      chk("t4_overrun_cleared", 32'(dl_overrun), 0);

      // 4b: drop on the same cycle as a download rise sets overrun again
      k = cyc;
      vid_req = 1'b1; vid_addr = 25'h401;
      sq.push_back('{1'b0, 25'h401, 8'h00, k + 1});
      vq.push_back('{rdval(25'h401), k + 5});
      sq.push_back('{1'b1, 25'h0899C, 8'h77, k + 6});
      tick();
      ioctl_wr = 1'b1; ioctl_addr = 25'd7; ioctl_data = 8'h77;
      tick();
      ioctl_wr = 1'b0; ioctl_download = 1'b0;
      tick();
      ioctl_download = 1'b1; ioctl_wr = 1'b1; ioctl_addr = 25'd8; ioctl_data = 8'h88;
      tick();
      ioctl_wr = 1'b0;
      chk("t4b_overrun_set_wins", 32'(dl_overrun), 1);
      drain();
      ioctl_download = 1'b0;
      tick();
      ioctl_download = 1'b1;
      tick();
      chk("t4b_overrun_cleared", 32'(dl_overrun), 0);

      // 5: continuous download starves the CPU for two windows only; video still wins
      k = cyc;
      sq.push_back('{1'b1, 25'h089A5, 8'hB0, k + 2});
      sq.push_back('{1'b1, 25'h089A6, 8'hB1, k + 7});
      sq.push_back('{1'b0, 25'h00500, 8'h00, k + 12});
      cq.push_back('{rdval(25'h500), k + 16});
      sq.push_back('{1'b1, 25'h089A7, 8'hB2, k + 17});
      sq.push_back('{1'b0, 25'h00600, 8'h00, k + 22});
      vq.push_back('{rdval(25'h600), k + 26});
      sq.push_back('{1'b1, 25'h089A8, 8'hB3, k + 27});
      sq.push_back('{1'b1, 25'h00501, 8'h77, k + 32});
      cq.push_back('{rdval(25'h500), k + 36});
      idx = 0;
      for (int t = 0; t < 40; t++) begin
         ioctl_wr = 1'b0;
         if (t == 0 || t == 1 || t == 6 || t == 16) begin
            ioctl_wr = 1'b1; ioctl_addr = 25'h10 + 25'(idx); ioctl_data = 8'hB0 + 8'(idx);
            idx++;
         end
         if (t == 1) begin
            cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 25'h500;
         end
         if (t == 17) begin
            cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 25'h501; cpu_wdata = 8'h77;
            vid_req = 1'b1; vid_addr = 25'h600;
         end
         tick();
      end
      ioctl_wr = 1'b0; ioctl_download = 1'b0;
      drain();
      chk("t5_dl_overrun", 32'(dl_overrun), 0);

      // 6: reset in the middle of a window discards everything
      k = cyc;
      ioctl_download = 1'b1;
      vid_req = 1'b1; vid_addr = 25'h700;
      sq.push_back('{1'b0, 25'h700, 8'h00, k + 1});
      vq.push_back('{rdval(25'h700), k + 5});
      tick();
      ioctl_wr = 1'b1; ioctl_addr = 25'd9; ioctl_data = 8'h99;
      tick();
      ioctl_wr = 1'b0; ioctl_download = 1'b0;
      chk("t6_rd_seen", sq.size(), 0);
      chk("t6_busy_before_reset", 32'(dl_busy), 1);
      reset_n = 1'b0;
      #1;
      vid_req = 1'b0;
      chk("t6_sdram_rd", 32'(sdram_rd), 0);
      chk("t6_sdram_wr", 32'(sdram_wr), 0);
      chk("t6_vid_ack", 32'(vid_ack), 0);
      chk("t6_cpu_ack", 32'(cpu_ack), 0);
      chk("t6_cpu_rdata", 32'(cpu_rdata), 0);
      chk("t6_dl_busy", 32'(dl_busy), 0);
      vq.delete();
      repeat (2) tick();
      reset_n = 1'b1;
      repeat (12) tick();
      chk("t6_dl_busy_after", 32'(dl_busy), 0);
      chk("t6_vid_data", 32'(vid_data), 0);

      $display("%0d/%0d checks passed", npass, nchk);
      $finish;
   end

endmodule
